// File: rtl/spio_hss_multiplexer_handshake_ctrl.sv
// Link handshake controller for the HSS multiplexer: two-phase version handshake,
// PHASE1 timeout, error-rate supervision in COMPLETE and a saturating reconnect counter.
//
// state    | meaning
// PHASE0   | idle, waiting for any matching handshake from the remote
// PHASE1   | transmitting phase 1, waiting for remote phase 1 (timed)
// COMPLETE | link usable, RX errors supervised per window
module spio_hss_multiplexer_handshake_ctrl #(
  parameter logic [7:0] PROTOCOL_VERSION = 8'h01,
  parameter int         HSHAKE_TIMEOUT   = 4095,
  parameter int         ERROR_THRESHOLD  = 8,
  parameter int         ERROR_WINDOW     = 65535
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic       RX_HSHAKE_VLD_IN,
  input  logic       RX_HSHAKE_PHASE_IN,
  input  logic [7:0] RX_HSHAKE_VERSION_IN,
  input  logic       RX_ERROR_IN,
  output logic       HANDSHAKE_COMPLETE_OUT,
  output logic       HANDSHAKE_PHASE_OUT,
  output logic       VERSION_MISMATCH_OUT,
  output logic       RESTART_OUT,
  output logic [7:0] REG_RECONNECT_CNT_OUT
);

  localparam int TW = $clog2(HSHAKE_TIMEOUT + 1);
  localparam int WW = $clog2(ERROR_WINDOW + 1);
  localparam int EW = $clog2(ERROR_THRESHOLD + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(HSHAKE_TIMEOUT);
  localparam logic [WW-1:0] WIN_LOAD = WW'(ERROR_WINDOW);
  localparam logic [EW-1:0] ERR_MAX  = EW'(ERROR_THRESHOLD);

  typedef enum logic [1:0] {PHASE0, PHASE1, COMPLETE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [WW-1:0]   win_q, win_d;
  logic [EW-1:0]   err_q, err_d;
  logic            mism_q, mism_d;
  logic            restart_q, restart_d;
  logic            complete_q, complete_d;
  logic            phase_q, phase_d;
  logic [7:0]      recon_q, recon_d;

  logic            match;
  logic            wrap;
  logic [EW-1:0]   err_base;
  logic [EW-1:0]   err_next;
  logic            err_hit;
  logic [7:0]      recon_inc;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    win_d      = win_q;
    err_d      = err_q;
    mism_d     = mism_q;
    restart_d  = 1'b0;
    recon_d    = recon_q;

    match     = RX_HSHAKE_VLD_IN && (RX_HSHAKE_VERSION_IN == PROTOCOL_VERSION);
    // Timers count down; the window and timeout fire when the last cycle is consumed.
    wrap      = (win_q <= WW'(1));
    err_base  = wrap ? '0 : err_q;
    err_next  = err_base + EW'(RX_ERROR_IN);
    err_hit   = RX_ERROR_IN && (err_next >= ERR_MAX);
    recon_inc = (recon_q == 8'hFF) ? recon_q : recon_q + 8'd1;

    if (RX_HSHAKE_VLD_IN && !match) begin
      mism_d = 1'b1;
    end else if (match) begin
      mism_d = 1'b0;
    end

    case (state_q)
      PHASE0: begin
        if (match) begin
          state_d = PHASE1;
          tmo_d   = TMO_LOAD;
        end
      end
      PHASE1: begin
        if (match && RX_HSHAKE_PHASE_IN) begin
          state_d = COMPLETE;
          err_d   = '0;
          win_d   = WIN_LOAD;
        end else if (match) begin
          tmo_d = TMO_LOAD;
        end else if (tmo_q <= TW'(1)) begin
          state_d   = PHASE0;
          restart_d = 1'b1;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      COMPLETE: begin
        win_d = wrap ? WIN_LOAD : win_q - WW'(1);
        err_d = err_next;
        // Error-driven restart beats a simultaneous remote phase-0 handshake.
        if (err_hit) begin
          state_d   = PHASE0;
          restart_d = 1'b1;
          recon_d   = recon_inc;
        end else if (match && !RX_HSHAKE_PHASE_IN) begin
          state_d   = PHASE1;
          tmo_d     = TMO_LOAD;
          restart_d = 1'b1;
          recon_d   = recon_inc;
        end
      end
      default: state_d = PHASE0;
    endcase

    complete_d = (state_d == COMPLETE);
    phase_d    = (state_d != PHASE0);
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q    <= PHASE0;
      tmo_q      <= '0;
      win_q      <= '0;
      err_q      <= '0;
      mism_q     <= 1'b0;
      restart_q  <= 1'b0;
      complete_q <= 1'b0;
      phase_q    <= 1'b0;
      recon_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      win_q      <= win_d;
      err_q      <= err_d;
      mism_q     <= mism_d;
      restart_q  <= restart_d;
      complete_q <= complete_d;
      phase_q    <= phase_d;
      recon_q    <= recon_d;
    end
  end

  assign HANDSHAKE_COMPLETE_OUT = complete_q;
  assign HANDSHAKE_PHASE_OUT    = phase_q;
  assign VERSION_MISMATCH_OUT   = mism_q;
  assign RESTART_OUT            = restart_q;
  assign REG_RECONNECT_CNT_OUT  = recon_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_handshake_ctrl.sv
// Scoreboard bench for spio_hss_multiplexer_handshake_ctrl: directed scenarios plus
// random traffic, checked every cycle against a cycle-count reference model.
module tb_spio_hss_multiplexer_handshake_ctrl;

  localparam logic [7:0] PV  = 8'h01;
  localparam int         TMO = 4095;
  localparam int         THR = 8;
  localparam int         WIN = 65535;

  localparam int S_IDLE = 0;
  localparam int S_WAIT = 1;
  localparam int S_LINK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic       ph  = 1'b0;
  logic [7:0] ver = 8'h00;
  logic       rxe = 1'b0;
  logic       comp_o, ph_o, mism_o, rst_o;
  logic [7:0] cnt_o;

  spio_hss_multiplexer_handshake_ctrl dut (
    .CLK_IN                 (clk),
    .RESET_IN               (rst),
    .RX_HSHAKE_VLD_IN       (vld),
    .RX_HSHAKE_PHASE_IN     (ph),
    .RX_HSHAKE_VERSION_IN   (ver),
    .RX_ERROR_IN            (rxe),
    .HANDSHAKE_COMPLETE_OUT (comp_o),
    .HANDSHAKE_PHASE_OUT    (ph_o),
    .VERSION_MISMATCH_OUT   (mism_o),
    .RESTART_OUT            (rst_o),
    .REG_RECONNECT_CNT_OUT  (cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic       comp;
    logic       ph;
    logic       mism;
    logic       rs;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: whole-cycle counts since the relevant event.
  int m_state, m_wait, m_errs, m_cic, m_recon;
  bit m_mism, m_rst;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && q.size() > 0 && q[0].tag == cyc) begin
      e = q.pop_front();
      checks++;
      if (comp_o !== e.comp || ph_o !== e.ph || mism_o !== e.mism ||
          rst_o !== e.rs || cnt_o !== e.cnt) begin
        errors++;
        $display("FAIL outputs cyc %0d: got comp=%b ph=%b mism=%b restart=%b cnt=%0d, expected comp=%b ph=%b mism=%b restart=%b cnt=%0d",
                 cyc, comp_o, ph_o, mism_o, rst_o, cnt_o, e.comp, e.ph, e.mism, e.rs, e.cnt);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_wait  = 0;
    m_errs  = 0;
    m_cic   = 0;
    m_recon = 0;
    m_mism  = 0;
    m_rst   = 0;
  endtask

  task automatic model_step(input bit v, input bit p, input logic [7:0] vr, input bit e);
    bit match;
    match = v && (vr == PV);
    m_rst = 0;
    if (v && !match) m_mism = 1;
    else if (match)  m_mism = 0;
    case (m_state)
      S_IDLE: if (match) begin m_state = S_WAIT; m_wait = 0; end
      S_WAIT: begin
        if (match && p) begin
          m_state = S_LINK; m_errs = 0; m_cic = 0;
        end else if (match) begin
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait >= TMO) begin m_state = S_IDLE; m_rst = 1; end
        end
      end
      default: begin
        m_cic++;
        if (m_cic == WIN) begin m_cic = 0; m_errs = 0; end
        if (e) m_errs++;
        if (e && m_errs >= THR) begin
          m_state = S_IDLE; m_rst = 1;
          if (m_recon < 255) m_recon++;
        end else if (match && !p) begin
          m_state = S_WAIT; m_wait = 0; m_rst = 1;
          if (m_recon < 255) m_recon++;
        end
      end
    endcase
  endtask

  task automatic step(input bit v, input bit p, input logic [7:0] vr, input bit e);
    exp_t x;
    vld = v; ph = p; ver = vr; rxe = e;
    model_step(v, p, vr, e);
    x.tag  = cyc + 1;
    x.comp = (m_state == S_LINK);
    x.ph   = (m_state != S_IDLE);
    x.mism = m_mism;
    x.rs   = m_rst;
    x.cnt  = 8'(m_recon);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, PV, 0);
  endtask

  task automatic do_reset(input string name);
    vld = 0; ph = 0; ver = 8'h00; rxe = 0;
    #2;
    rst = 1;
    q.delete();
    model_reset();
    #1;
    chk({name, " comp"},    int'(comp_o), 0);
    chk({name, " phase"},   int'(ph_o),   0);
    chk({name, " mism"},    int'(mism_o), 0);
    chk({name, " restart"}, int'(rst_o),  0);
    chk({name, " cnt"},     int'(cnt_o),  0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int r;
    model_reset();
    do_reset("reset");
    idle(3);

    // Basic two-phase handshake
    step(1, 0, PV, 0);
    chk("p0 match phase", int'(ph_o), 1);
    chk("p0 match comp",  int'(comp_o), 0);
    step(1, 1, PV, 0);
    chk("p1 match comp", int'(comp_o), 1);

    // Version mismatch in COMPLETE, then a matching phase-1 word clears it
    step(1, 0, 8'h02, 0);
    chk("mismatch flag", int'(mism_o), 1);
    chk("mismatch no transition", int'(comp_o), 1);
    step(1, 1, PV, 0);
    chk("mismatch cleared", int'(mism_o), 0);
    chk("phase1 ignored in complete", int'(comp_o), 1);
    chk("phase1 ignored no restart", int'(rst_o), 0);

    // Error threshold
    for (int i = 0; i < THR - 1; i++) step(0, 0, PV, 1);
    chk("7 errors stay complete", int'(comp_o), 1);
    step(0, 0, PV, 1);
    chk("8th error comp", int'(comp_o), 0);
    chk("8th error phase", int'(ph_o), 0);
    chk("8th error restart", int'(rst_o), 1);
    chk("8th error cnt", int'(cnt_o), 1);
    idle(1);
    chk("restart one cycle", int'(rst_o), 0);

    // Window wrap clears the error count; an error on the wrap cycle counts as one
    step(1, 1, PV, 0);
    step(1, 1, PV, 0);
    for (int i = 0; i < THR - 1; i++) step(0, 0, PV, 1);
    idle(WIN - THR);
    step(0, 0, PV, 1);
    chk("error on wrap stays complete", int'(comp_o), 1);
    for (int i = 0; i < THR - 2; i++) step(0, 0, PV, 1);
    chk("7 after wrap stays complete", int'(comp_o), 1);
    step(0, 0, PV, 1);
    chk("8 after wrap restarts", int'(comp_o), 0);
    chk("8 after wrap cnt", int'(cnt_o), 2);

    // PHASE1 timeout
    step(1, 0, PV, 0);
    idle(TMO - 1);
    chk("timeout-1 phase", int'(ph_o), 1);
    chk("timeout-1 restart", int'(rst_o), 0);
    idle(1);
    chk("timeout restart", int'(rst_o), 1);
    chk("timeout phase", int'(ph_o), 0);
    chk("timeout cnt unchanged", int'(cnt_o), 2);
    idle(1);
    chk("timeout restart one cycle", int'(rst_o), 0);

    // Match on the timeout cycle wins
    step(1, 0, PV, 0);
    idle(TMO - 1);
    step(1, 0, PV, 0);
    chk("match at timeout phase", int'(ph_o), 1);
    chk("match at timeout restart", int'(rst_o), 0);
    step(1, 1, PV, 0);
    chk("complete after reload", int'(comp_o), 1);

    // 8th error together with remote phase-0 handshake: error wins
    for (int i = 0; i < THR - 1; i++) step(0, 0, PV, 1);
    step(1, 0, PV, 1);
    chk("collision phase", int'(ph_o), 0);
    chk("collision restart", int'(rst_o), 1);
    chk("collision cnt", int'(cnt_o), 3);
    idle(1);
    chk("collision single pulse", int'(rst_o), 0);

    // Reconnect count saturation
    step(1, 1, PV, 0);
    step(1, 1, PV, 0);
    for (int i = 0; i < 300; i++) begin
      step(1, 0, PV, 0);
      step(1, 1, PV, 0);
    end
    chk("reconnect saturation", int'(cnt_o), 255);
    chk("complete after reconnects", int'(comp_o), 1);

    do_reset("reset in complete");
    idle(2);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bit v, p, e;
      logic [7:0] vr;
      r  = int'($urandom_range(0, 99));
      v  = (r < 30);
      p  = $urandom_range(0, 1) == 1;
      vr = ($urandom_range(0, 9) < 8) ? PV : 8'($urandom_range(0, 255));
      e  = ($urandom_range(0, 9) == 0);
      step(v, p, vr, e);
    end

    step(1, 0, PV, 0);
    do_reset("reset in phase1");
    idle(2);

    @(negedge clk);
    #1;
    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spio_hss_multiplexer_handshake_ctrl.md
SPIO_HSS_MULTIPLEXER_HANDSHAKE_CTRL -- requirements
Module: spio_hss_multiplexer_handshake_ctrl

Interface
REQ-001 SHALL have parameter PROTOCOL_VERSION, default 8'h01, version carried in and expected from handshake words.
REQ-002 SHALL have parameter HSHAKE_TIMEOUT, default 4095, cycles without a valid handshake in PHASE1 before restart.
REQ-003 SHALL have parameter ERROR_THRESHOLD, default 8, RX errors within one window that force a restart.
REQ-004 SHALL have parameter ERROR_WINDOW, default 65535, length of the error-counting window in cycles.
REQ-005 SHALL have ports: CLK_IN in 1 clock; RESET_IN in 1 reset, asynchronous, active-high.
REQ-006 SHALL have ports: RX_HSHAKE_VLD_IN in 1 one-cycle strobe, aligned handshake word received; RX_HSHAKE_PHASE_IN in 1 phase bit of that word; RX_HSHAKE_VERSION_IN in 8 version byte of that word.
REQ-007 SHALL have port RX_ERROR_IN in 1, one-cycle strobe per decode error or loss of sync.
REQ-008 SHALL have ports: HANDSHAKE_COMPLETE_OUT out 1, link usable; HANDSHAKE_PHASE_OUT out 1, phase to transmit.
REQ-009 SHALL have ports: VERSION_MISMATCH_OUT out 1, sticky mismatch flag; RESTART_OUT out 1, one-cycle restart pulse; REG_RECONNECT_CNT_OUT out 8, saturating count of restarts from COMPLETE.

Function
REQ-010 SHALL implement states PHASE0, PHASE1, COMPLETE; all outputs registered, changing on the clock edge after the causing input.
REQ-011 "Match" SHALL mean RX_HSHAKE_VLD_IN=1 and RX_HSHAKE_VERSION_IN=PROTOCOL_VERSION.
REQ-012 PHASE0: match (either phase) -> PHASE1; no timeout in PHASE0.
REQ-013 PHASE1: match with phase=1 -> COMPLETE; match with phase=0 -> stay and reload timeout counter.
REQ-014 PHASE1: timeout counter increments each cycle without match; reaching HSHAKE_TIMEOUT -> PHASE0, RESTART_OUT pulses.
REQ-015 PHASE1: match on the same cycle the timeout is reached SHALL win (no restart).
REQ-016 COMPLETE: match with phase=0 (remote restarted) -> PHASE1, RESTART_OUT pulses, reconnect count increments.
REQ-017 COMPLETE: match with phase=1 SHALL be ignored.
REQ-018 COMPLETE: error counter increments on RX_ERROR_IN; when it reaches ERROR_THRESHOLD -> PHASE0, RESTART_OUT pulses, reconnect count increments.
REQ-019 COMPLETE: window counter free-runs; on reaching ERROR_WINDOW it wraps to 0 and clears the error counter; an error on the wrap cycle counts as 1.
REQ-020 COMPLETE: threshold error and phase-0 match on the same cycle -> PHASE0 (error priority), single pulse, single increment.
REQ-021 Error and window counters SHALL be cleared on every entry to COMPLETE; RX_ERROR_IN ignored outside COMPLETE.
REQ-022 HANDSHAKE_COMPLETE_OUT=1 iff state=COMPLETE; HANDSHAKE_PHASE_OUT=1 iff state is PHASE1 or COMPLETE.
REQ-023 VERSION_MISMATCH_OUT SHALL set on RX_HSHAKE_VLD_IN with wrong version (any state) and clear on the next match.
REQ-024 A mismatched-version handshake SHALL cause no state transition and no timeout reload.
REQ-025 REG_RECONNECT_CNT_OUT SHALL saturate at 255.

Reset
REQ-026 On RESET_IN: state PHASE0; HANDSHAKE_COMPLETE_OUT=0, HANDSHAKE_PHASE_OUT=0, VERSION_MISMATCH_OUT=0, RESTART_OUT=0, REG_RECONNECT_CNT_OUT=0; all counters 0.
REQ-027 Reset asserted mid-handshake or in COMPLETE SHALL take effect immediately, without a RESTART_OUT pulse.

Verification
REQ-028 After reset, match phase=0 then match phase=1 -> PHASE_OUT=1 after the first, COMPLETE_OUT=1 the cycle after the second.
REQ-029 In PHASE1, no handshakes for 4095 cycles -> PHASE0, RESTART_OUT high exactly 1 cycle; a match at cycle 4095 instead keeps PHASE1.
REQ-030 In COMPLETE, 8 RX_ERROR_IN strobes within 65535 cycles -> PHASE0, REG_RECONNECT_CNT_OUT=1; 7 strobes then window wrap then 1 strobe -> stays COMPLETE.
REQ-031 Handshake with version 8'h02 -> VERSION_MISMATCH_OUT=1, no state change; next version 8'h01 handshake clears it.
REQ-032 In COMPLETE, phase-0 match together with the 8th error -> PHASE0, one pulse, count +1; force 300 reconnects -> count holds at 255.
